// File: rtl/td4_pkg.sv
// Shared opcodes, control-word layout and default widths for the TD4-style core.
package td4_pkg;

    localparam int unsigned DW_DEF = 4;
    localparam int unsigned AW_DEF = 4;
    localparam int unsigned OPW    = 4;

    localparam logic [OPW-1:0] OP_ADD_A  = 4'b0000;
    localparam logic [OPW-1:0] OP_MOV_AB = 4'b0001;
    localparam logic [OPW-1:0] OP_IN_A   = 4'b0010;
    localparam logic [OPW-1:0] OP_MOV_AI = 4'b0011;
    localparam logic [OPW-1:0] OP_MOV_BA = 4'b0100;
    localparam logic [OPW-1:0] OP_ADD_B  = 4'b0101;
    localparam logic [OPW-1:0] OP_IN_B   = 4'b0110;
    localparam logic [OPW-1:0] OP_MOV_BI = 4'b0111;
    localparam logic [OPW-1:0] OP_ADD_AB = 4'b1000;
    localparam logic [OPW-1:0] OP_OUT_B  = 4'b1001;
    localparam logic [OPW-1:0] OP_NOP    = 4'b1010;
    localparam logic [OPW-1:0] OP_OUT_I  = 4'b1011;
    localparam logic [OPW-1:0] OP_JC     = 4'b1100;
    localparam logic [OPW-1:0] OP_HLT    = 4'b1101;
    localparam logic [OPW-1:0] OP_JNC    = 4'b1110;
    localparam logic [OPW-1:0] OP_JMP    = 4'b1111;

    // Adder Y-operand source
    typedef enum logic [1:0] {
        SEL_A    = 2'd0,
        SEL_B    = 2'd1,
        SEL_IN   = 2'd2,
        SEL_ZERO = 2'd3
    } sel_e;

    typedef struct packed {
        logic ld_a;
        logic ld_b;
        logic ld_out;
        logic ld_pc;
        sel_e sel;
        logic upd_c;
        logic halt;
        logic add_ab;
    } ctrl_t;

endpackage

// File: rtl/td4_decoder.sv
// Combinational opcode decoder: opcode plus current carry to control word.
module td4_decoder
    import td4_pkg::*;
(
    input  logic [OPW-1:0] i_op,
    input  logic           i_carry,
    output ctrl_t          o_ctrl_c
);

    always_comb begin
        o_ctrl_c     = '0;
        o_ctrl_c.sel = SEL_ZERO;
        case (i_op)
            OP_ADD_A:  begin o_ctrl_c.ld_a   = 1'b1; o_ctrl_c.sel = SEL_A;    o_ctrl_c.upd_c = 1'b1; end
            OP_MOV_AB: begin o_ctrl_c.ld_a   = 1'b1; o_ctrl_c.sel = SEL_B;    o_ctrl_c.upd_c = 1'b1; end
            OP_IN_A:   begin o_ctrl_c.ld_a   = 1'b1; o_ctrl_c.sel = SEL_IN;   o_ctrl_c.upd_c = 1'b1; end
            OP_MOV_AI: begin o_ctrl_c.ld_a   = 1'b1; o_ctrl_c.sel = SEL_ZERO; o_ctrl_c.upd_c = 1'b1; end
            OP_MOV_BA: begin o_ctrl_c.ld_b   = 1'b1; o_ctrl_c.sel = SEL_A;    o_ctrl_c.upd_c = 1'b1; end
            OP_ADD_B:  begin o_ctrl_c.ld_b   = 1'b1; o_ctrl_c.sel = SEL_B;    o_ctrl_c.upd_c = 1'b1; end
            OP_IN_B:   begin o_ctrl_c.ld_b   = 1'b1; o_ctrl_c.sel = SEL_IN;   o_ctrl_c.upd_c = 1'b1; end
            OP_MOV_BI: begin o_ctrl_c.ld_b   = 1'b1; o_ctrl_c.sel = SEL_ZERO; o_ctrl_c.upd_c = 1'b1; end
            OP_ADD_AB: begin
                o_ctrl_c.ld_a   = 1'b1;
                o_ctrl_c.sel    = SEL_A;
                o_ctrl_c.upd_c  = 1'b1;
                o_ctrl_c.add_ab = 1'b1;
            end
            OP_OUT_B:  begin o_ctrl_c.ld_out = 1'b1; o_ctrl_c.sel = SEL_B;    o_ctrl_c.upd_c = 1'b1; end
            OP_OUT_I:  begin o_ctrl_c.ld_out = 1'b1; o_ctrl_c.sel = SEL_ZERO; o_ctrl_c.upd_c = 1'b1; end
            // Control ops leave the carry flag untouched
            OP_JC:     o_ctrl_c.ld_pc = i_carry;
            OP_JNC:    o_ctrl_c.ld_pc = ~i_carry;
            OP_JMP:    o_ctrl_c.ld_pc = 1'b1;
            OP_HLT:    o_ctrl_c.halt  = 1'b1;
            OP_NOP:    o_ctrl_c.upd_c = 1'b0;
            default:   o_ctrl_c.upd_c = 1'b0;
        endcase
    end

endmodule

// File: rtl/td4_core_param.sv
// Parametrised TD4-style single-cycle core; program ROM is external on a combinational fetch port.
module td4_core_param
    import td4_pkg::*;
#(
    parameter int unsigned DW = DW_DEF,
    parameter int unsigned AW = AW_DEF
) (
    input  logic              CK,
    input  logic              RST_N,
    input  logic              RUN,
    output logic [AW-1:0]     IMEM_AD,
    input  logic [OPW+DW-1:0] IMEM_Q,
    input  logic [DW-1:0]     IN_PORT,
    output logic [DW-1:0]     OUT_PORT,
    output logic              OUT_VALID,
    output logic              CARRY,
    output logic              HALTED
);

    logic [AW-1:0]  r_pc;
    logic [DW-1:0]  r_a;
    logic [DW-1:0]  r_b;
    logic [DW-1:0]  r_out;
    logic           r_carry;
    logic           r_out_valid;
    logic           r_halted;

    logic [OPW-1:0] w_op;
    logic [DW-1:0]  w_im;
    ctrl_t          w_ctrl;
    logic [DW-1:0]  w_y;
    logic [DW-1:0]  w_opnd;
    logic [DW:0]    w_sum;
    logic           w_en;

    assign w_op = IMEM_Q[OPW+DW-1:DW];
    assign w_im = IMEM_Q[DW-1:0];

    td4_decoder u_dec (
        .i_op     (w_op),
        .i_carry  (r_carry),
        .o_ctrl_c (w_ctrl)
    );

    // Input-select mux feeding the adder
    always_comb begin
        w_y = '0;
        case (w_ctrl.sel)
            SEL_A:    w_y = r_a;
            SEL_B:    w_y = r_b;
            SEL_IN:   w_y = IN_PORT;
            default:  w_y = '0;
        endcase
    end

    assign w_opnd = w_ctrl.add_ab ? r_b : w_im;
    assign w_sum  = {1'b0, w_y} + {1'b0, w_opnd};
    assign w_en   = RUN & ~r_halted;

    always_ff @(posedge CK or negedge RST_N) begin
        if (!RST_N) begin
            r_pc        <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_out       <= '0;
            r_carry     <= 1'b0;
            r_out_valid <= 1'b0;
            r_halted    <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            if (w_en) begin
                if (w_ctrl.ld_a)   r_a   <= w_sum[DW-1:0];
                if (w_ctrl.ld_b)   r_b   <= w_sum[DW-1:0];
                if (w_ctrl.ld_out) begin
                    r_out       <= w_sum[DW-1:0];
                    r_out_valid <= 1'b1;
                end
                if (w_ctrl.upd_c)  r_carry <= w_sum[DW];
                // HLT freezes the PC on its own address
                if (w_ctrl.halt) begin
                    r_halted <= 1'b1;
                end else if (w_ctrl.ld_pc) begin
                    r_pc <= w_im[AW-1:0];
                end else begin
                    r_pc <= r_pc + AW'(1);
                end
            end
        end
    end

    assign IMEM_AD   = r_pc;
    assign OUT_PORT  = r_out;
    assign OUT_VALID = r_out_valid;
    assign CARRY     = r_carry;
    assign HALTED    = r_halted;

endmodule

// File: tb/tb_td4_core_param.sv
// Randomised scoreboard bench for td4_core_param in 4/4 and 8/6 width configurations.
module tb_td4_core_param;

    typedef struct {
        int pc;
        int a;
        int b;
        int out;
        int c;
        int h;
        int ov;
    } st_t;

    typedef struct {
        st_t s4;
        st_t s8;
    } snap_t;

    logic        CK;
    logic        RST_N;
    logic        RUN;
    logic [3:0]  in4;
    logic [7:0]  in8;

    logic [3:0]  ad4;
    logic [7:0]  q4;
    logic [3:0]  out4;
    logic        ov4, c4, h4;

    logic [5:0]  ad8;
    logic [11:0] q8;
    logic [7:0]  out8;
    logic        ov8, c8, h8;

    logic [7:0]  rom4 [16];
    logic [11:0] rom8 [64];

    snap_t q[$];
    st_t   m4, m8, st_rst;
    int    checks = 0;
    int    errors = 0;

    assign q4 = rom4[ad4];
    assign q8 = rom8[ad8];

    td4_core_param #(.DW(4), .AW(4)) u_dut4 (
        .CK(CK), .RST_N(RST_N), .RUN(RUN), .IMEM_AD(ad4), .IMEM_Q(q4),
        .IN_PORT(in4), .OUT_PORT(out4), .OUT_VALID(ov4), .CARRY(c4), .HALTED(h4)
    );

    td4_core_param #(.DW(8), .AW(6)) u_dut8 (
        .CK(CK), .RST_N(RST_N), .RUN(RUN), .IMEM_AD(ad8), .IMEM_Q(q8),
        .IN_PORT(in8), .OUT_PORT(out8), .OUT_VALID(ov8), .CARRY(c8), .HALTED(h8)
    );

    initial CK = 1'b0;
    always #5 CK = ~CK;

    task automatic chk(input string name, input logic [31:0] act, input int exp);
        checks++;
        if (act !== 32'(exp)) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural reference: one instruction of the ISA with integer arithmetic
    function automatic st_t step(st_t s, bit run, int word, int inp, int dw, int aw);
        int  mask  = (1 << dw) - 1;
        int  amask = (1 << aw) - 1;
        int  op    = (word >> dw) & 15;
        int  im    = word & mask;
        int  sum   = 0;
        int  tgt   = 0;
        bit  wr    = 1'b1;
        st_t n     = s;
        n.ov = 0;
        if (!run || s.h != 0) return n;
        n.pc = (s.pc + 1) & amask;
        case (op)
            0:  begin sum = s.a + im;   tgt = 0; end
            1:  begin sum = s.b + im;   tgt = 0; end
            2:  begin sum = inp + im;   tgt = 0; end
            3:  begin sum = im;         tgt = 0; end
            4:  begin sum = s.a + im;   tgt = 1; end
            5:  begin sum = s.b + im;   tgt = 1; end
            6:  begin sum = inp + im;   tgt = 1; end
            7:  begin sum = im;         tgt = 1; end
            8:  begin sum = s.a + s.b;  tgt = 0; end
            9:  begin sum = s.b + im;   tgt = 2; end
            11: begin sum = im;         tgt = 2; end
            12: begin wr = 1'b0; if (s.c != 0) n.pc = im & amask; end
            13: begin wr = 1'b0; n.h = 1; n.pc = s.pc; end
            14: begin wr = 1'b0; if (s.c == 0) n.pc = im & amask; end
            15: begin wr = 1'b0; n.pc = im & amask; end
            default: wr = 1'b0;
        endcase
        if (wr) begin
            n.c = (sum >> dw) & 1;
            if (tgt == 0)      n.a = sum & mask;
            else if (tgt == 1) n.b = sum & mask;
            else begin
                n.out = sum & mask;
                n.ov  = 1;
            end
        end
        return n;
    endfunction

    task automatic push_snap();
        snap_t s;
        s.s4 = m4;
        s.s8 = m8;
        q.push_back(s);
    endtask

    // One clock: drive at the falling edge, advance the model at the rising edge
    task automatic cycle(input bit run, input bit rstn);
        int inv;
        int w4, w8;
        @(negedge CK);
        inv   = $urandom;
        RUN   = run;
        RST_N = rstn;
        in4   = inv[3:0];
        in8   = inv[7:0];
        @(posedge CK);
        w4 = int'(rom4[m4.pc]);
        w8 = int'(rom8[m8.pc]);
        if (!rstn) begin
            m4 = st_rst;
            m8 = st_rst;
        end else begin
            m4 = step(m4, run, w4, int'(in4), 4, 4);
            m8 = step(m8, run, w8, int'(in8), 8, 6);
        end
        push_snap();
    endtask

    // Assert reset between edges and check it takes effect without a clock
    task automatic reset_drop();
        #2;
        RST_N = 1'b0;
        m4 = st_rst;
        m8 = st_rst;
        q.delete();
        push_snap();
        #1;
        chk("rst_pc4",  32'(ad4),  0);
        chk("rst_out4", 32'(out4), 0);
        chk("rst_ov4",  32'(ov4),  0);
        chk("rst_c4",   32'(c4),   0);
        chk("rst_h4",   32'(h4),   0);
        chk("rst_pc8",  32'(ad8),  0);
        chk("rst_h8",   32'(h8),   0);
    endtask

    // Monitor: every falling edge the DUTs present state; compare against the queued model snapshot
    initial begin
        snap_t e;
        forever begin
            @(negedge CK);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("pc4",  32'(ad4),  e.s4.pc);
                chk("out4", 32'(out4), e.s4.out);
                chk("ov4",  32'(ov4),  e.s4.ov);
                chk("c4",   32'(c4),   e.s4.c);
                chk("h4",   32'(h4),   e.s4.h);
                chk("pc8",  32'(ad8),  e.s8.pc);
                chk("out8", 32'(out8), e.s8.out);
                chk("ov8",  32'(ov8),  e.s8.ov);
                chk("c8",   32'(c8),   e.s8.c);
                chk("h8",   32'(h8),   e.s8.h);
            end
        end
    end

    initial begin
        st_rst = '{pc: 0, a: 0, b: 0, out: 0, c: 0, h: 0, ov: 0};
        m4 = st_rst;
        m8 = st_rst;
        RST_N = 1'b0;
        RUN   = 1'b0;
        in4   = '0;
        in8   = '0;

        // Directed program: carry, conditional jumps, I/O, back-to-back OUT, wrap
        rom4 = '{8'h39, 8'h08, 8'hE0, 8'hC6, 8'hA0, 8'hA0, 8'h21, 8'hBA,
                 8'h40, 8'h90, 8'h91, 8'h80, 8'h93, 8'hEF, 8'hFF, 8'hA0};
        for (int i = 0; i < 64; i++) rom8[i] = 12'hA00;
        rom8[0]  = 12'h3F0;
        rom8[1]  = 12'h020;
        rom8[2]  = 12'h380;
        rom8[3]  = 12'h780;
        rom8[4]  = 12'h800;
        rom8[5]  = 12'h400;
        rom8[6]  = 12'h900;
        rom8[7]  = 12'hF7F;
        rom8[63] = 12'hB55;
        push_snap();
        cycle(1'b0, 1'b0);
        for (int i = 0; i < 40; i++) begin
            if (i >= 4 && i < 7) cycle(1'b0, 1'b1);
            else if (i < 16)     cycle(1'b1, 1'b1);
            else                 cycle($urandom_range(0, 9) != 0, 1'b1);
        end
        reset_drop();
        cycle(1'b1, 1'b0);
        for (int i = 0; i < 20; i++) cycle(1'b1, 1'b1);

        // HLT at address 7 must freeze the PC while RUN stays high
        reset_drop();
        for (int i = 0; i < 16; i++) rom4[i] = 8'hA0;
        for (int i = 0; i < 64; i++) rom8[i] = 12'hA00;
        for (int i = 0; i < 7; i++) begin
            rom4[i] = 8'(8'h30 + i);
            rom8[i] = 12'(12'h3F8 + i);
        end
        rom4[7] = 8'hD0;
        rom8[7] = 12'hD00;
        cycle(1'b1, 1'b0);
        for (int i = 0; i < 20; i++) cycle(1'b1, 1'b1);
        #1;
        chk("halt_flag4", 32'(h4),  1);
        chk("halt_pc4",   32'(ad4), 7);
        chk("halt_pc8",   32'(ad8), 7);

        // Random programs with random stalls and inputs
        for (int r = 0; r < 8; r++) begin
            reset_drop();
            for (int i = 0; i < 16; i++) rom4[i] = 8'($urandom);
            for (int i = 0; i < 64; i++) rom8[i] = 12'($urandom);
            cycle(1'b1, 1'b0);
            for (int i = 0; i < 60; i++) cycle($urandom_range(0, 4) != 0, 1'b1);
        end

        @(negedge CK);
        #1;
        chk("drain", 32'(q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/td4_core_param.md
Name: td4_core_param

Overview:
- Parametrised successor of the 4-bit TD4-style CPU datapath: PC, registers A/B/OUT, input-select mux, adder, carry flag and opcode decoder in one clocked core.
- Generalised to DW-bit data and AW-bit program address.
- Adds asynchronous reset, run/stall enable, HLT, JC, ADD A,B, NOP and an OUT strobe.
- Program ROM sits outside the core on a combinational fetch port. Top level instantiates ROM + core.

Parameters:
- DW, 4, data/immediate width; instruction word is {OP[3:0], IM[DW-1:0]}.
- AW, 4, program-counter width; constraint AW <= DW.

Ports:
- CK  input  1  clock; all state changes on rising edge.
- RST_N  input  1  reset, asynchronous, active-low.
- RUN  input  1  1 = execute one instruction per cycle; 0 = stall, all state held.
- IMEM_AD  output  AW  fetch address (= PC).
- IMEM_Q  input  4+DW  instruction at IMEM_AD; combinational, same cycle.
- IN_PORT  input  DW  external input operand.
- OUT_PORT  output  DW  output register.
- OUT_VALID  output  1  registered 1-cycle pulse, high the cycle after OUT_PORT is written.
- CARRY  output  1  carry flag.
- HALTED  output  1  high once HLT has executed.

Behaviour:
- Reset (RST_N=0, asynchronous): PC=0, A=B=OUT_PORT=0, CARRY=0, OUT_VALID=0, HALTED=0. Applies immediately, including mid-program. The first instruction executes on the first rising edge with RST_N=1 and RUN=1.
- Execution: single cycle. Decode IMEM_Q; the result is written on the rising edge where RUN=1 and HALTED=0.
- ALU: sum = {0,Y} + {0,IM} (or {0,A} + {0,B} for ADD A,B), DW+1 bits. The result takes the low DW bits; carry is bit DW.
- Opcodes (write target = sum; CARRY updated):
  - 0000 ADD A,Im: A = A+Im
  - 0001 MOV A,B: A = B+Im
  - 0010 IN A: A = IN_PORT+Im
  - 0011 MOV A,Im: A = 0+Im
  - 0100 MOV B,A: B = A+Im
  - 0101 ADD B,Im: B = B+Im
  - 0110 IN B: B = IN_PORT+Im
  - 0111 MOV B,Im: B = 0+Im
  - 1000 ADD A,B: A = A+B
  - 1001 OUT B: OUT = B+Im
  - 1011 OUT Im: OUT = 0+Im
- Control opcodes (CARRY unchanged):
  - 1010 NOP
  - 1100 JC Im: PC = IM[AW-1:0] if CARRY=1
  - 1101 HLT: HALTED <= 1, PC held
  - 1110 JNC Im: PC = IM[AW-1:0] if CARRY=0
  - 1111 JMP Im: PC = IM[AW-1:0]
- Jump condition uses the CARRY value before the edge.
- PC: otherwise PC+1 modulo 2^AW; 2^AW-1 wraps to 0.
- OUT_VALID: 1 for exactly the cycle after an OUT edge, else 0. Back-to-back OUTs hold it high for consecutive cycles.
- Stall (RUN=0): nothing changes; OUT_VALID drops to 0 on the next edge.
- Halted: all state frozen until reset. HALTED overrides RUN, and OUT_VALID drops to 0.
- Carry rule change from the original core: jumps, NOP and HLT do not clear CARRY.
- Simultaneous events: reset dominates every event; halted dominates RUN.

Decomposition:
- Package td4_pkg holds:
  - opcode localparams (OP_ADD_A … OP_JMP);
  - the control-word field layout: ld_a, ld_b, ld_out, ld_pc, sel[1:0], upd_c, halt, add_ab;
  - defaults DW_DEF=4, AW_DEF=4.
- Sub-module td4_decoder: combinational OP + CARRY → control word. The core holds all state, the mux and the adder.

Test Plan:
- Reset: run a program, drop RST_N between clock edges → all outputs and PC go to 0 immediately; after release, the instruction at address 0 executes.
- Carry and conditional jumps (DW=4):
  - MOV A,9; ADD A,8 → A=0001, CARRY=1.
  - JNC 0 at addr 2 → not taken, PC=3.
  - JC 6 at addr 3 → PC=6, CARRY still 1.
- I/O:
  - IN_PORT=0110, IN A Im=1 → A=0111.
  - OUT Im=1010 → OUT_PORT=1010, OUT_VALID high one cycle only.
  - OUT B twice in a row → two-cycle pulse.
- Stall/halt:
  - RUN=0 for 3 cycles → PC, A, B and CARRY unchanged.
  - HLT at addr 7 → HALTED=1, PC stays 7 for 10 cycles even with RUN=1.
  - Reset clears HALTED.
- Wrap: NOP at addr 15 (AW=4) → PC=0 next cycle.
- Width config (DW=8, AW=6):
  - MOV A,0xF0; ADD A,0x20 → A=0x10, CARRY=1.
  - JMP 0x7F → PC=0x3F (IM truncated to AW).
  - ADD A,B with A=0x80, B=0x80 → A=0x00, CARRY=1.
